// File: rtl/aes_pkg.sv
// Shared AES-128 constants, FSM state type and round-step helper functions.
package aes_pkg;

    localparam int AES_NR = 10;
    localparam int BLK_W  = 128;
    localparam int KS_W   = 1408;

    typedef enum logic {
        IDLE,
        RUN
    } fsm_e;

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        return {
            xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)
        };
    endfunction

    function automatic logic [BLK_W-1:0] sub_bytes(input logic [BLK_W-1:0] s);
        logic [BLK_W-1:0] o;
        for (int i = 0; i < 16; i++) begin
            o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
        end
        return o;
    endfunction

    // Byte i sits at row i%4, column i/4; row r rotates left by r columns.
    function automatic logic [BLK_W-1:0] shift_rows(input logic [BLK_W-1:0] s);
        logic [BLK_W-1:0] o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [BLK_W-1:0] mix_columns(input logic [BLK_W-1:0] s);
        logic [BLK_W-1:0] o;
        for (int c = 0; c < 4; c++) begin
            o[127-32*c -: 32] = mix_col(s[127-32*c -: 32]);
        end
        return o;
    endfunction

    function automatic logic [BLK_W-1:0] rk(
        input logic [KS_W-1:0] key,
        input logic [3:0]      r
    );
        return key[KS_W-1-128*int'(r) -: 128];
    endfunction

endpackage

// File: rtl/aes_round_unit.sv
// Combinational AES round: SubBytes, ShiftRows, MixColumns (skipped on the
// final round) and AddRoundKey.
module aes_round_unit
    import aes_pkg::*;
(
    input  logic [BLK_W-1:0] st,
    input  logic [BLK_W-1:0] rkey,
    input  logic             last,
    output logic [BLK_W-1:0] nxt
);

    logic [BLK_W-1:0] sr;

    always_comb begin
        sr  = shift_rows(sub_bytes(st));
        nxt = (last ? sr : mix_columns(sr)) ^ rkey;
    end

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryption sequencer, one round per clock over Nr = 10.
// Define AES_CTRL_ABORT_EN to add an `abort` input that cancels a running block.
module aes_round_ctrl
    import aes_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef AES_CTRL_ABORT_EN
    input  logic             abort,
`endif
    input  logic [KS_W-1:0]  key,
    input  logic [BLK_W-1:0] state,
    output logic [BLK_W-1:0] out,
    output logic             busy,
    output logic             done,
    output logic [3:0]       round
);

    fsm_e             fsm_q, fsm_d;
    logic [BLK_W-1:0] st_q, st_d;
    logic [BLK_W-1:0] out_q, out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [3:0]       round_q, round_d;

    logic             abort_w;
    logic             last;
    logic [BLK_W-1:0] rnd_out;

`ifdef AES_CTRL_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    assign last = (round_q == 4'(AES_NR));

    aes_round_unit u_round (
        .st   (st_q),
        .rkey (rk(key, round_q)),
        .last (last),
        .nxt  (rnd_out)
    );

    always_comb begin
        fsm_d   = fsm_q;
        st_d    = st_q;
        out_d   = out_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        round_d = round_q;
        unique case (fsm_q)
            IDLE: begin
                if (start) begin
                    st_d    = state ^ rk(key, 4'd0);
                    round_d = 4'd1;
                    busy_d  = 1'b1;
                    fsm_d   = RUN;
                end
            end
            RUN: begin
                // Abort wins over the final-round completion.
                if (abort_w) begin
                    busy_d  = 1'b0;
                    round_d = 4'd0;
                    fsm_d   = IDLE;
                end else if (last) begin
                    out_d   = rnd_out;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    round_d = 4'd0;
                    fsm_d   = IDLE;
                end else begin
                    st_d    = rnd_out;
                    round_d = round_q + 4'd1;
                end
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fsm_q   <= IDLE;
            st_q    <= '0;
            out_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            round_q <= 4'd0;
        end else begin
            fsm_q   <= fsm_d;
            st_q    <= st_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            round_q <= round_d;
        end
    end

    assign out   = out_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign round = round_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl: FIPS-197 vectors, back-to-back,
// reset and ignored-start cases, plus abort cases when AES_CTRL_ABORT_EN is set.
module tb_aes_round_ctrl;

    logic          clk;
    logic          rst;
    logic          start;
    logic          abort;
    logic [1407:0] key;
    logic [127:0]  state;
    logic [127:0]  out;
    logic          busy;
    logic          done;
    logic [3:0]    round;

    int total = 0;
    int bad   = 0;

    logic [7:0] sb [256];

    aes_round_ctrl dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
`ifdef AES_CTRL_ABORT_EN
        .abort (abort),
`endif
        .key   (key),
        .state (state),
        .out   (out),
        .busy  (busy),
        .done  (done),
        .round (round)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // ---------------- reference AES built from GF(2^8) arithmetic
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                  ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [1407:0] expand(input logic [127:0] k);
        logic [31:0]   w [44];
        logic [31:0]   t;
        logic [7:0]    rc = 8'h01;
        logic [1407:0] ks;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sb[t[23:16]] ^ rc, sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 44; i++) ks[1407-32*i -: 32] = w[i];
        return ks;
    endfunction

    function automatic logic [127:0] aes_model(input logic [1407:0] ks,
                                               input logic [127:0] pt);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ ks[1407-8*i -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
            for (int c = 0; c < 4; c++)
                for (int w = 0; w < 4; w++)
                    s[4*c+w] = t[4*((c+w)%4)+w];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gmul(a0, 2) ^ gmul(a1, 3) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 2) ^ gmul(a2, 3) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 2) ^ gmul(a3, 3);
                    s[4*c+3] = gmul(a0, 3) ^ a1 ^ a2 ^ gmul(a3, 2);
                end
            end
            for (int i = 0; i < 16; i++) s[i] ^= ks[1407-128*r-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // ---------------- cycle-level protocol model
    logic          m_valid = 1'b0;
    logic          m_busy  = 1'b0;
    logic          m_done  = 1'b0;
    logic [127:0]  m_out   = '0;
    int            m_cnt   = 0;
    logic [127:0]  m_pt;
    logic [1407:0] m_key;

    always @(posedge clk) begin
        if (!rst) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_out  = '0;
            m_cnt  = 0;
        end else begin
            m_done = 1'b0;
            if (!m_busy) begin
                if (start) begin
                    m_busy = 1'b1;
                    m_cnt  = 0;
                    m_pt   = state;
                    m_key  = key;
                end
            end else if (abort) begin
                m_busy = 1'b0;
                m_cnt  = 0;
            end else if (m_cnt == 9) begin
                m_out  = aes_model(m_key, m_pt);
                m_done = 1'b1;
                m_busy = 1'b0;
                m_cnt  = 0;
            end else begin
                m_cnt++;
            end
        end
        m_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("cyc_out", out, m_out);
            chk("cyc_busy", 128'(busy), 128'(m_busy));
            chk("cyc_done", 128'(done), 128'(m_done));
            chk("cyc_round", 128'(round), m_busy ? 128'(m_cnt + 1) : 128'd0);
        end
    end

    // ---------------- directed stimulus
    localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT2 = 128'h3925841d02dc09fbdc118597196a0b32;

    logic [1407:0] ks1, ks2;

    task automatic run_block(input logic [1407:0] k, input logic [127:0] pt,
                             input logic [127:0] exp, input string nm);
        bit seen = 0;
        @(negedge clk);
        key = k;
        state = pt;
        start = 1'b1;
        for (int n = 1; n <= 16 && !seen; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (n <= 10) chk({nm, "_round"}, 128'(round), 128'(n));
            if (done) begin
                seen = 1;
                chk({nm, "_latency"}, 128'(n), 128'd11);
                chk({nm, "_out"}, out, exp);
            end
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: no done within 16 cycles", nm);
        end
    endtask

    task automatic wait_round(input logic [3:0] r, input string nm);
        bit hit = 0;
        for (int n = 0; n < 20 && !hit; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (round == r) hit = 1;
        end
        if (!hit) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: round %0d never reached", nm, r);
        end
    endtask

    task automatic count_dones(input int cycles, output int cnt);
        cnt = 0;
        for (int n = 0; n < cycles; n++) begin
            @(negedge clk);
            if (done) cnt++;
        end
    endtask

    initial begin
        int nd;
        int last_n;
        int dc;
        rst   = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        key   = '0;
        state = '0;
        build_sbox();
        ks1 = expand(K1);
        ks2 = expand(K2);

        chk("model_rk10", ks2[127:0], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        chk("model_c1", aes_model(ks1, PT1), CT1);
        chk("model_b", aes_model(ks2, PT2), CT2);

        @(negedge clk);
        chk("rst_out", out, 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_done", 128'(done), 128'd0);
        chk("rst_round", 128'(round), 128'd0);
        @(negedge clk);
        rst = 1'b1;

        run_block(ks1, PT1, CT1, "c1");
        run_block(ks2, PT2, CT2, "b");

        // Back-to-back with start held high, alternating vectors per accept.
        @(negedge clk);
        key = ks1;
        state = PT1;
        start = 1'b1;
        nd = 0;
        last_n = 0;
        for (int n = 1; n <= 60 && nd < 4; n++) begin
            @(negedge clk);
            if (done) begin
                chk("b2b_out", out, (nd % 2 == 0) ? CT1 : CT2);
                if (nd > 0) chk("b2b_period", 128'(n - last_n), 128'd11);
                last_n = n;
                nd++;
                key   = (nd % 2 == 1) ? ks2 : ks1;
                state = (nd % 2 == 1) ? PT2 : PT1;
            end
        end
        start = 1'b0;
        chk("b2b_count", 128'(nd), 128'd4);

        // Reset in the middle of a block.
        @(negedge clk);
        key = ks1;
        state = PT1;
        start = 1'b1;
        wait_round(4'd5, "mid_rst");
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("mid_rst_out", out, 128'd0);
        chk("mid_rst_busy", 128'(busy), 128'd0);
        chk("mid_rst_done", 128'(done), 128'd0);
        chk("mid_rst_round", 128'(round), 128'd0);
        run_block(ks2, PT2, CT2, "post_rst");

        // Start while busy must be dropped.
        @(negedge clk);
        key = ks1;
        state = PT1;
        start = 1'b1;
        wait_round(4'd3, "ign");
        state = PT2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        state = PT1;
        count_dones(12, dc);
        chk("ign_dones", 128'(dc), 128'd1);
        chk("ign_out", out, CT1);
        count_dones(14, dc);
        chk("ign_extra", 128'(dc), 128'd0);

`ifdef AES_CTRL_ABORT_EN
        run_block(ks2, PT2, CT2, "pre_abort");
        @(negedge clk);
        key = ks1;
        state = PT1;
        start = 1'b1;
        wait_round(4'd7, "ab7");
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("ab7_busy", 128'(busy), 128'd0);
        chk("ab7_round", 128'(round), 128'd0);
        chk("ab7_out", out, CT2);
        count_dones(14, dc);
        chk("ab7_dones", 128'(dc), 128'd0);

        @(negedge clk);
        start = 1'b1;
        wait_round(4'd10, "ab10");
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("ab10_done", 128'(done), 128'd0);
        chk("ab10_busy", 128'(busy), 128'd0);
        chk("ab10_out", out, CT2);
        count_dones(5, dc);
        chk("ab10_dones", 128'(dc), 128'd0);
`endif

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
